// File: rtl/voice_slot_alloc.sv
// Polyphonic voice allocator: note-on takes the lowest free voice, note-off releases the matching voice.
// Optional VOICE_STEAL_EN: when all voices are busy, a rotating pointer picks the voice to reassign.
module voice_slot_alloc #(
    parameter int VOICES = 8,
    parameter int NOTE_W = 7
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    input  logic              req_on_i,
    input  logic [NOTE_W-1:0] req_note_i,
    output logic              req_ready_o,
    output logic              alloc_valid_o,
    output logic [VOICES-1:0] alloc_slot_o,
    output logic [NOTE_W-1:0] alloc_note_o,
    output logic              rel_valid_o,
    output logic [VOICES-1:0] rel_slot_o,
    output logic [VOICES-1:0] busy_o,
    output logic              full_o,
    output logic              drop_o
);

    localparam int IDX_W = (VOICES > 1) ? $clog2(VOICES) : 1;

    typedef enum logic [1:0] {IDLE, FIND, COMMIT} state_t;

    state_t            state_q;
    logic              req_on_q;
    logic [NOTE_W-1:0] req_note_q;
    logic [VOICES-1:0] busy_q;
    logic [NOTE_W-1:0] note_q [VOICES];
    logic              alloc_valid_q;
    logic [VOICES-1:0] alloc_slot_q;
    logic [NOTE_W-1:0] alloc_note_q;
    logic              rel_valid_q;
    logic [VOICES-1:0] rel_slot_q;
    logic              drop_q;

    logic [VOICES-1:0] match_d;
    logic [VOICES-1:0] free_d;
    logic [IDX_W-1:0]  free_idx_d;

    // Scan from the top down so the lowest qualifying slot is the one that sticks.
    always_comb begin
        match_d    = '0;
        free_d     = '0;
        free_idx_d = '0;
        for (int i = VOICES - 1; i >= 0; i--) begin
            if (busy_q[i] && (note_q[i] == req_note_q)) begin
                match_d = VOICES'(1) << i;
            end
            if (!busy_q[i]) begin
                free_d     = VOICES'(1) << i;
                free_idx_d = IDX_W'(i);
            end
        end
    end

`ifdef VOICE_STEAL_EN
    logic [VOICES-1:0] steal_q;
    logic [IDX_W-1:0]  steal_idx_d;

    always_comb begin
        steal_idx_d = '0;
        for (int i = 0; i < VOICES; i++) begin
            if (steal_q[i]) steal_idx_d = IDX_W'(i);
        end
    end
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            req_on_q      <= 1'b0;
            req_note_q    <= '0;
            busy_q        <= '0;
            for (int i = 0; i < VOICES; i++) note_q[i] <= '0;
            alloc_valid_q <= 1'b0;
            alloc_slot_q  <= '0;
            alloc_note_q  <= '0;
            rel_valid_q   <= 1'b0;
            rel_slot_q    <= '0;
            drop_q        <= 1'b0;
`ifdef VOICE_STEAL_EN
            steal_q       <= VOICES'(1);
`endif
        end else begin
            alloc_valid_q <= 1'b0;
            alloc_slot_q  <= '0;
            rel_valid_q   <= 1'b0;
            rel_slot_q    <= '0;
            drop_q        <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        req_on_q   <= req_on_i;
                        req_note_q <= req_note_i;
                        state_q    <= FIND;
                    end
                end
                FIND: begin
                    // Decision is registered here so the result pulses for the whole COMMIT cycle.
                    state_q <= COMMIT;
                    if (req_on_q) begin
                        if (match_d != '0) begin
                            alloc_valid_q <= 1'b1;
                            alloc_slot_q  <= match_d;
                            alloc_note_q  <= req_note_q;
                        end else if (free_d != '0) begin
                            busy_q             <= busy_q | free_d;
                            note_q[free_idx_d] <= req_note_q;
                            alloc_valid_q      <= 1'b1;
                            alloc_slot_q       <= free_d;
                            alloc_note_q       <= req_note_q;
                        end else begin
`ifdef VOICE_STEAL_EN
                            note_q[steal_idx_d] <= req_note_q;
                            alloc_valid_q       <= 1'b1;
                            alloc_slot_q        <= steal_q;
                            alloc_note_q        <= req_note_q;
                            rel_valid_q         <= 1'b1;
                            rel_slot_q          <= steal_q;
                            steal_q             <= {steal_q[VOICES-2:0], steal_q[VOICES-1]};
`else
                            drop_q <= 1'b1;
`endif
                        end
                    end else if (match_d != '0) begin
                        busy_q      <= busy_q & ~match_d;
                        rel_valid_q <= 1'b1;
                        rel_slot_q  <= match_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready_o   = (state_q == IDLE);
    assign alloc_valid_o = alloc_valid_q;
    assign alloc_slot_o  = alloc_slot_q;
    assign alloc_note_o  = alloc_note_q;
    assign rel_valid_o   = rel_valid_q;
    assign rel_slot_o    = rel_slot_q;
    assign busy_o        = busy_q;
    assign full_o        = &busy_q;
    assign drop_o        = drop_q;

endmodule
